lock_key_loader: RTL and testbench

//  Serial key-load controller for the keyed (MUX + XOR locked) c432 netlist.

---
 rtl/lock_key_pkg.sv | 26 ++
 rtl/lock_key_shreg.sv | 51 +++++
 rtl/lock_key_loader.sv | 133 +++++++++++++
 tb/tb_lock_key_loader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lock_key_pkg.sv
// Shared definitions for the serial key loader of the locked c432 netlist.
// Key layout: bits [31:0] drive X_1..X_32 (bit i -> X_{i+1}), bits [35:32] drive p1..p4.
// Optional feature macro: LOCK_KEY_PARITY_EN (adds one trailing even-parity bit per load).
package lock_key_pkg;

  localparam int KEY_W_DEF   = 36;
  localparam int CNT_W_DEF   = 6;
  localparam int GAP_MAX_DEF = 15;

  // Key field positions within the committed key bus
  localparam int P_LSB = 32;
  localparam int X_LSB = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    CHECK   = 2'd2,
    ARMED   = 2'd3
  } lk_state_e;

  // The loader counts as busy while a load is being shifted or checked
  function automatic logic state_busy(input lk_state_e s);
    return (s == LOADING) || (s == CHECK);
  endfunction

endpackage

// File: rtl/lock_key_shreg.sv
// Shadow shift register with bit counter for the key loader.
// Bits enter MSB first; done_o flags the cycle that shifts in the final bit.
// Width SH_W is supplied by the top (grows by one when LOCK_KEY_PARITY_EN is defined).
module lock_key_shreg
  import lock_key_pkg::*;
#(
  parameter int SH_W  = KEY_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            shift_i,
  input  logic            bit_i,
  output logic [SH_W-1:0] shadow_o,
  output logic            done_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SH_W - 1);

  logic [SH_W-1:0]  shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: a clear (new load or key_clear) wins over shifting a bit in
  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    if (clear_i) begin
      shadow_d = '0;
      cnt_d    = '0;
    end else if (shift_i) begin
      shadow_d = {shadow_q[SH_W-2:0], bit_i};
      cnt_d    = cnt_q + 1'b1;
    end
  end

  // Shadow and counter registers; reset discards any partial key immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      cnt_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign shadow_o = shadow_q;
  assign done_o   = shift_i && !clear_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/lock_key_loader.sv
// Serial key-load controller: shifts a key in, checks it, and commits it atomically
// to the key bus of the locked c432 core so the core never sees a partial key.
// Optional feature macro: LOCK_KEY_PARITY_EN (one trailing even-parity bit, checked before commit).
module lock_key_loader
  import lock_key_pkg::*;
#(
  parameter int KEY_W   = KEY_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int GAP_MAX = GAP_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_start,
  input  logic             key_valid,
  input  logic             key_bit,
  input  logic             key_clear,
  output logic [KEY_W-1:0] key_out,
  output logic             key_armed,
  output logic             busy,
  output logic             load_err
);

`ifdef LOCK_KEY_PARITY_EN
  localparam int SH_W = KEY_W + 1;
`else
  localparam int SH_W = KEY_W;
`endif
  localparam int GAP_W = $clog2(GAP_MAX + 1);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(GAP_MAX);

  lk_state_e        state_q;
  logic [KEY_W-1:0] key_out_q;
  logic             armed_q;
  logic             err_q;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic [SH_W-1:0]  shadow;
  logic [KEY_W-1:0] shadow_key;
  logic             start_load;
  logic             sh_clear;
  logic             shift_en;
  logic             last_bit;
  logic             check_ok;

  assign start_load = key_start && !key_clear && ((state_q == IDLE) || (state_q == ARMED));
  assign sh_clear   = key_clear || start_load;
  assign shift_en   = (state_q == LOADING) && key_valid && !key_clear;
  assign gap_d      = gap_q + 1'b1;
  assign shadow_key = shadow[SH_W-1 -: KEY_W];

`ifdef LOCK_KEY_PARITY_EN
  assign check_ok = ~(^shadow);
`else
  assign check_ok = 1'b1;
`endif

  lock_key_shreg #(
    .SH_W  (SH_W),
    .CNT_W (CNT_W)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (sh_clear),
    .shift_i  (shift_en),
    .bit_i    (key_bit),
    .shadow_o (shadow),
    .done_o   (last_bit)
  );

  // Load FSM with registered commit: key_clear overrides everything, aborts zero the live key
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      key_out_q <= '0;
      armed_q   <= 1'b0;
      err_q     <= 1'b0;
      gap_q     <= '0;
    end else if (key_clear) begin
      state_q   <= IDLE;
      key_out_q <= '0;
      armed_q   <= 1'b0;
      err_q     <= 1'b0;
      gap_q     <= '0;
    end else begin
      case (state_q)
        IDLE, ARMED: begin
          if (key_start) begin
            state_q <= LOADING;
            gap_q   <= '0;
            err_q   <= 1'b0;
          end
        end
        LOADING: begin
          if (key_valid) begin
            gap_q <= '0;
            if (last_bit) begin
              state_q <= CHECK;
            end
          end else if (gap_d == GAP_LIMIT) begin
            state_q   <= IDLE;
            key_out_q <= '0;
            armed_q   <= 1'b0;
            err_q     <= 1'b1;
            gap_q     <= '0;
          end else begin
            gap_q <= gap_d;
          end
        end
        CHECK: begin
          if (check_ok) begin
            state_q   <= ARMED;
            key_out_q <= shadow_key;
            armed_q   <= 1'b1;
          end else begin
            state_q   <= IDLE;
            key_out_q <= '0;
            armed_q   <= 1'b0;
            err_q     <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign key_out   = key_out_q;
  assign key_armed = armed_q;
  assign load_err  = err_q;
  assign busy      = state_busy(state_q);

endmodule

// File: tb/tb_lock_key_loader.sv
// Directed self-checking bench for lock_key_loader.
// Build with LOCK_KEY_PARITY_EN defined to also exercise the trailing parity bit.
module tb_lock_key_loader;

  localparam int KEY_W = 36;
`ifdef LOCK_KEY_PARITY_EN
  localparam int NBITS = KEY_W + 1;
  logic flipPar = 1'b0;
`else
  localparam int NBITS = KEY_W;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             key_start = 1'b0;
  logic             key_valid = 1'b0;
  logic             key_bit = 1'b0;
  logic             key_clear = 1'b0;
  logic [KEY_W-1:0] key_out;
  logic             key_armed;
  logic             busy;
  logic             load_err;

  int checks = 0;
  int failures = 0;
  int busyCycles = 0;
  int busyBase;

  lock_key_loader dut (
    .clk       (clk),
    .rst       (rst),
    .key_start (key_start),
    .key_valid (key_valid),
    .key_bit   (key_bit),
    .key_clear (key_clear),
    .key_out   (key_out),
    .key_armed (key_armed),
    .busy      (busy),
    .load_err  (load_err)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  // Count sampled cycles with busy high, away from the active edge
  always @(negedge clk) begin
    if (busy) busyCycles++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [KEY_W-1:0] expKey, input logic expArmed,
                          input logic expBusy, input logic expErr);
    checkOutput({tag, ".key_out"}, 64'(key_out), 64'(expKey));
    checkOutput({tag, ".key_armed"}, 64'(key_armed), 64'(expArmed));
    checkOutput({tag, ".busy"}, 64'(busy), 64'(expBusy));
    checkOutput({tag, ".load_err"}, 64'(load_err), 64'(expErr));
  endtask

  // Drive one clock edge worth of inputs, then return them to idle
  task automatic applyStimulus(input logic s, input logic c, input logic v, input logic b);
    key_start = s;
    key_clear = c;
    key_valid = v;
    key_bit   = b;
    @(posedge clk);
    #1;
    key_start = 1'b0;
    key_clear = 1'b0;
    key_valid = 1'b0;
    key_bit   = 1'b0;
  endtask

  task automatic sendBits(input logic [KEY_W-1:0] key, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) applyStimulus(1'b0, 1'b0, 1'b1, key[i]);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Full load: start pulse, MSB-first bits with optional idle gaps after given bit counts
  task automatic loadKey(input logic [KEY_W-1:0] key, input int gapAt1, input int len1,
                         input int gapAt2, input int len2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = KEY_W - 1; i >= 0; i--) begin
      applyStimulus(1'b0, 1'b0, 1'b1, key[i]);
      if (KEY_W - i == gapAt1) idleCycles(len1);
      if (KEY_W - i == gapAt2) idleCycles(len2);
    end
`ifdef LOCK_KEY_PARITY_EN
    applyStimulus(1'b0, 1'b0, 1'b1, (^key) ^ flipPar);
`endif
  endtask

  initial begin
    logic [KEY_W-1:0] kA;
    logic [KEY_W-1:0] kB;
    logic [KEY_W-1:0] kC;
    kA = 36'h9_A5A5_1234;
    kB = 36'h0_0000_00FF;
    kC = 36'h1_FFFF_0000;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset.held", '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    checkAll("reset.released", '0, 1'b0, 1'b0, 1'b0);

    // Test 1: back-to-back load, commit two cycles after last bit
    busyBase = busyCycles;
    loadKey(kA, -1, 0, -1, 0);
    @(negedge clk);
    checkAll("t1.check", '0, 1'b0, 1'b1, 1'b0);
    idleCycles(1);
    @(negedge clk);
    checkAll("t1.commit", kA, 1'b1, 1'b0, 1'b0);
    idleCycles(2);
    checkOutput("t1.busy_cycles", 64'(busyCycles - busyBase), 64'(NBITS + 1));

    // Test 2: gaps of 5 after bits 10 and 20, from a cleared key
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkAll("t2.cleared", '0, 1'b0, 1'b0, 1'b0);
    loadKey(kA, 10, 5, 20, 5);
    @(negedge clk);
    checkAll("t2.check", '0, 1'b0, 1'b1, 1'b0);
    idleCycles(1);
    @(negedge clk);
    checkAll("t2.commit", kA, 1'b1, 1'b0, 1'b0);

    // Test 3: re-load from ARMED stalls after bit 7; 14 idle cycles survive, the 15th aborts
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    sendBits(kB, KEY_W - 1, KEY_W - 7);
    idleCycles(14);
    @(negedge clk);
    checkAll("t3.gap14", kA, 1'b1, 1'b1, 1'b0);
    idleCycles(1);
    @(negedge clk);
    checkAll("t3.abort", '0, 1'b0, 1'b0, 1'b1);

    // Test 4: arm 0xFF, re-load 0x1FFFF0000 with an ignored key_start mid-load
    loadKey(kB, -1, 0, -1, 0);
    idleCycles(1);
    @(negedge clk);
    checkAll("t4.armed_ff", kB, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    sendBits(kC, KEY_W - 1, 20);
    @(negedge clk);
    checkAll("t4.midload", kB, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, kC[19]);
    sendBits(kC, 18, 0);
`ifdef LOCK_KEY_PARITY_EN
    applyStimulus(1'b0, 1'b0, 1'b1, ^kC);
`endif
    @(negedge clk);
    checkAll("t4.check", kB, 1'b1, 1'b1, 1'b0);
    idleCycles(1);
    @(negedge clk);
    checkAll("t4.commit", kC, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkAll("t4.start_clear", '0, 1'b0, 1'b0, 1'b0);
    idleCycles(1);
    @(negedge clk);
    checkAll("t4.stay_idle", '0, 1'b0, 1'b0, 1'b0);

    // Test 5: asynchronous reset at bit 20 of a re-load, then a fresh load
    loadKey(kB, -1, 0, -1, 0);
    idleCycles(1);
    @(negedge clk);
    checkAll("t5.armed_ff", kB, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    sendBits(kA, KEY_W - 1, KEY_W - 20);
    #2;
    rst = 1'b1;
    #1;
    checkAll("t5.async_rst", '0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkAll("t5.after_rst", '0, 1'b0, 1'b0, 1'b0);
    loadKey(kA, -1, 0, -1, 0);
    idleCycles(1);
    @(negedge clk);
    checkAll("t5.commit", kA, 1'b1, 1'b0, 1'b0);

`ifdef LOCK_KEY_PARITY_EN
    // Test 6: parity bit 1 on key 1 commits; parity bit 0 rejects and zeroes the key
    flipPar = 1'b0;
    loadKey(36'h0_0000_0001, -1, 0, -1, 0);
    idleCycles(1);
    @(negedge clk);
    checkAll("t6.par_good", 36'h0_0000_0001, 1'b1, 1'b0, 1'b0);
    flipPar = 1'b1;
    loadKey(36'h0_0000_0001, -1, 0, -1, 0);
    idleCycles(1);
    @(negedge clk);
    checkAll("t6.par_bad", '0, 1'b0, 1'b0, 1'b1);
    flipPar = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
